// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: buffers branch resolutions, filters them into
// install/invalidate writes and runs full-table invalidates on flush.
module btb_update_ctrl #(
    parameter int PCW      = 30,
    parameter int NENTRIES = 4,
    parameter int IDXW     = 2,
    parameter int QDEPTH   = 2,
    parameter int CNTW     = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [PCW-1:0]      res_pc,
    input  logic [PCW-1:0]      res_target,
    input  logic                res_taken,
    input  logic                res_hit,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                flush_done,
    output logic                btb_we,
    output logic [IDXW-1:0]     btb_idx,
    output logic                btb_valid,
    output logic [PCW-IDXW-1:0] btb_tag,
    output logic [PCW-1:0]      btb_target,
    input  logic                btb_wr_ack,
    output logic [CNTW-1:0]     install_cnt
);

    localparam int PTRW = $clog2(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH_WAIT,
        FLUSH
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [IDXW-1:0]     idx;
        logic [PCW-IDXW-1:0] tag;
        logic [PCW-1:0]      target;
    } wr_t;

    wr_t             q [QDEPTH];
    logic [PTRW:0]   wptr;
    logic [PTRW:0]   rptr;
    state_t          state;
    logic            flush_pend;
    logic [IDXW-1:0] fidx;
    logic            done_q;
    logic [CNTW-1:0] cnt;

    logic empty;
    logic full;
    logic in_flush;
    logic enq;
    logic fire;
    logic deq;
    wr_t  head;
    wr_t  new_wr;

    always_comb begin
        empty    = (wptr == rptr);
        full     = (wptr[PTRW] != rptr[PTRW]) &&
                   (wptr[PTRW-1:0] == rptr[PTRW-1:0]);
        in_flush = (state == FLUSH);
        head     = q[rptr[PTRW-1:0]];

        res_ready = (state == IDLE) && !full && !flush_pend;
        enq       = res_valid && res_ready && (res_taken || res_hit);

        new_wr.valid  = res_taken;
        new_wr.idx    = res_pc[IDXW-1:0];
        new_wr.tag    = res_pc[PCW-1:IDXW];
        new_wr.target = res_taken ? res_target : '0;

        btb_we     = in_flush || !empty;
        btb_idx    = '0;
        btb_valid  = 1'b0;
        btb_tag    = '0;
        btb_target = '0;
        if (in_flush) begin
            btb_idx = fidx;
        end else if (!empty) begin
            btb_idx    = head.idx;
            btb_valid  = head.valid;
            btb_tag    = head.tag;
            btb_target = head.target;
        end

        fire = btb_we && btb_wr_ack;
        deq  = fire && !in_flush;

        flush_busy  = flush_pend;
        flush_done  = done_q;
        install_cnt = cnt;
    end

    // Entry storage needs no reset; it is only observed behind the pointers.
    always_ff @(posedge CLK) begin
        if (enq) begin
            q[wptr[PTRW-1:0]] <= new_wr;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr       <= '0;
            rptr       <= '0;
            state      <= IDLE;
            flush_pend <= 1'b0;
            fidx       <= '0;
            done_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            done_q <= 1'b0;
            if (fire && btb_valid && (cnt != {CNTW{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    wptr <= wptr + (PTRW+1)'(enq);
                    rptr <= rptr + (PTRW+1)'(deq);
                    if (flush_req) begin
                        flush_pend <= 1'b1;
                        state      <= FLUSH_WAIT;
                        // Head already written: nothing is in flight, drop the rest.
                        if (deq) begin
                            wptr <= wptr;
                            rptr <= wptr;
                        end
                    end
                end
                FLUSH_WAIT: begin
                    if (empty || fire) begin
                        rptr  <= wptr;
                        fidx  <= '0;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fire) begin
                        if (fidx == IDXW'(NENTRIES-1)) begin
                            state      <= IDLE;
                            flush_pend <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            fidx <= fidx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected BTB writes are queued
// as stimulus is driven and checked as each write is acked.
module tb_btb_update_ctrl;

    logic        CLK;
    logic        nRST;
    logic        res_valid;
    logic        res_ready;
    logic [29:0] res_pc;
    logic [29:0] res_target;
    logic        res_taken;
    logic        res_hit;
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;
    logic        btb_we;
    logic [1:0]  btb_idx;
    logic        btb_valid;
    logic [27:0] btb_tag;
    logic [29:0] btb_target;
    logic        btb_wr_ack;
    logic [15:0] install_cnt;

    logic        s_res_ready;
    logic        s_flush_busy;
    logic        s_flush_done;
    logic        s_btb_we;
    logic [1:0]  s_btb_idx;
    logic        s_btb_valid;
    logic [27:0] s_btb_tag;
    logic [29:0] s_btb_target;
    logic [1:0]  s_install_cnt;

    btb_update_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target),
        .res_taken(res_taken), .res_hit(res_hit),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .flush_done(flush_done), .btb_we(btb_we),
        .btb_idx(btb_idx), .btb_valid(btb_valid),
        .btb_tag(btb_tag), .btb_target(btb_target),
        .btb_wr_ack(btb_wr_ack), .install_cnt(install_cnt)
    );

    btb_update_ctrl #(.CNTW(2)) dut_sat (
        .CLK(CLK), .nRST(nRST),
        .res_valid(res_valid), .res_ready(s_res_ready),
        .res_pc(res_pc), .res_target(res_target),
        .res_taken(res_taken), .res_hit(res_hit),
        .flush_req(flush_req), .flush_busy(s_flush_busy),
        .flush_done(s_flush_done), .btb_we(s_btb_we),
        .btb_idx(s_btb_idx), .btb_valid(s_btb_valid),
        .btb_tag(s_btb_tag), .btb_target(s_btb_target),
        .btb_wr_ack(btb_wr_ack), .install_cnt(s_install_cnt)
    );

    typedef struct packed {
        logic        v;
        logic [1:0]  idx;
        logic [27:0] tag;
        logic [29:0] tgt;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests;
    int  n_fail;
    int  exp_cnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic wr_t mk(input logic taken, input logic [29:0] pc,
                               input logic [29:0] tgt);
        wr_t w;
        w.v   = taken;
        w.idx = pc[1:0];
        w.tag = pc[29:2];
        w.tgt = taken ? tgt : 30'd0;
        return w;
    endfunction

    function automatic wr_t mk_flush(input int i);
        wr_t w;
        w     = '0;
        w.idx = 2'(i);
        return w;
    endfunction

    task automatic drive(input logic v, input logic taken, input logic hit,
                         input logic [29:0] pc, input logic [29:0] tgt);
        res_valid  = v;
        res_taken  = taken;
        res_hit    = hit;
        res_pc     = pc;
        res_target = tgt;
    endtask

    // One clock; an acked write is popped from the scoreboard and compared.
    task automatic cyc();
        wr_t e;
        wr_t got;
        if (nRST && btb_we && btb_wr_ack) begin
            got = {btb_valid, btb_idx, btb_tag, btb_target};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected got v=%0d idx=%0d tag=%h tgt=%h",
                         got.v, got.idx, got.tag, got.tgt);
            end else begin
                e = exp_q.pop_front();
                if (e.v) exp_cnt++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL write_fields got v=%0d idx=%0d tag=%h tgt=%h exp v=%0d idx=%0d tag=%h tgt=%h",
                             got.v, got.idx, got.tag, got.tgt,
                             e.v, e.idx, e.tag, e.tgt);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        btb_wr_ack = 1'b0;
        flush_req = 1'b0;
        drive(0, 0, 0, 30'd0, 30'd0);
        cyc();
        cyc();
        n_tests++;
        if ({res_ready, btb_we, flush_busy, flush_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 1000",
                     {res_ready, btb_we, flush_busy, flush_done});
        end
        n_tests++;
        if ({btb_idx, btb_valid, btb_tag, btb_target} !== 61'd0) begin
            n_fail++;
            $display("FAIL reset_fields got %h exp 0",
                     {btb_idx, btb_valid, btb_tag, btb_target});
        end
        n_tests++;
        if (install_cnt !== 16'd0 || s_install_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got %0d/%0d exp 0", install_cnt, s_install_cnt);
        end
        nRST = 1'b1;
        cyc();
    endtask

    task automatic test_install();
        btb_wr_ack = 1'b1;
        drive(1, 1, 0, 30'h0000123, 30'h0000400);
        exp_q.push_back(mk(1, 30'h0000123, 30'h0000400));
        cyc();
        drive(0, 0, 0, 30'd0, 30'd0);
        n_tests++;
        if ({btb_we, btb_idx, btb_valid, btb_tag, btb_target} !==
            {1'b1, 2'd3, 1'b1, 28'h0000048, 30'h0000400}) begin
            n_fail++;
            $display("FAIL install_out got we=%0d idx=%0d v=%0d tag=%h tgt=%h exp 1 3 1 48 400",
                     btb_we, btb_idx, btb_valid, btb_tag, btb_target);
        end
        cyc();
        n_tests++;
        if (install_cnt !== 16'd1 || btb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL install_cnt got cnt=%0d we=%0d exp cnt=1 we=0",
                     install_cnt, btb_we);
        end
    endtask

    task automatic test_backpressure();
        btb_wr_ack = 1'b0;
        drive(1, 1, 0, 30'h10, 30'h100);
        n_tests++;
        if (res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_first got %0d exp 1", res_ready);
        end
        exp_q.push_back(mk(1, 30'h10, 30'h100));
        cyc();
        drive(1, 1, 0, 30'h11, 30'h101);
        exp_q.push_back(mk(1, 30'h11, 30'h101));
        cyc();
        drive(1, 1, 0, 30'h12, 30'h102);
        n_tests++;
        if (res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_full got %0d exp 0", res_ready);
        end
        cyc();
        n_tests++;
        if (btb_we !== 1'b1 || btb_tag !== 28'h4 || btb_target !== 30'h100) begin
            n_fail++;
            $display("FAIL bp_hold got we=%0d tag=%h tgt=%h exp 1 4 100",
                     btb_we, btb_tag, btb_target);
        end
        drive(0, 0, 0, 30'd0, 30'd0);
        btb_wr_ack = 1'b1;
        cyc();
        cyc();
        n_tests++;
        if (res_ready !== 1'b1 || btb_we !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain got ready=%0d we=%0d pending=%0d exp 1 0 0",
                     res_ready, btb_we, exp_q.size());
        end
    endtask

    task automatic test_filter();
        btb_wr_ack = 1'b1;
        drive(1, 0, 1, 30'h5, 30'h77);
        exp_q.push_back(mk(0, 30'h5, 30'h77));
        cyc();
        drive(0, 0, 0, 30'd0, 30'd0);
        n_tests++;
        if ({btb_we, btb_idx, btb_valid, btb_target} !== {1'b1, 2'd1, 1'b0, 30'd0}) begin
            n_fail++;
            $display("FAIL filter_inval got we=%0d idx=%0d v=%0d tgt=%h exp 1 1 0 0",
                     btb_we, btb_idx, btb_valid, btb_target);
        end
        cyc();
        drive(1, 0, 0, 30'h9, 30'h99);
        cyc();
        drive(0, 0, 0, 30'd0, 30'd0);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (btb_we !== 1'b0) begin
                n_fail++;
                $display("FAIL filter_drop got we=%0d exp 0", btb_we);
            end
            cyc();
        end
    endtask

    task automatic test_flush();
        int n;
        btb_wr_ack = 1'b0;
        drive(1, 1, 0, 30'h21, 30'h200);
        exp_q.push_back(mk(1, 30'h21, 30'h200));
        cyc();
        drive(1, 1, 0, 30'h22, 30'h201);
        cyc();
        drive(0, 0, 0, 30'd0, 30'd0);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({flush_busy, res_ready, btb_we} !== 3'b101 || btb_tag !== 28'h8) begin
                n_fail++;
                $display("FAIL flush_wait got busy=%0d ready=%0d we=%0d tag=%h exp 1 0 1 8",
                         flush_busy, res_ready, btb_we, btb_tag);
            end
            cyc();
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_flush(i));
        btb_wr_ack = 1'b1;
        n = 0;
        while (!flush_done && n < 20) begin
            n_tests++;
            if (flush_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_busy got %0d exp 1 at cycle %0d", flush_busy, n);
            end
            cyc();
            n++;
        end
        n_tests++;
        if (flush_done !== 1'b1 || n != 5) begin
            n_fail++;
            $display("FAIL flush_len got done=%0d cycles=%0d exp 1 5", flush_done, n);
        end
        n_tests++;
        if (flush_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_end got %0d exp 0", flush_busy);
        end
        cyc();
        n_tests++;
        if ({flush_done, res_ready, btb_we} !== 3'b010 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_after got done=%0d ready=%0d we=%0d pending=%0d exp 0 1 0 0",
                     flush_done, res_ready, btb_we, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_flush();
        btb_wr_ack = 1'b1;
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        cyc();
        exp_q.push_back(mk_flush(0));
        exp_q.push_back(mk_flush(1));
        cyc();
        cyc();
        n_tests++;
        if (btb_we !== 1'b1 || btb_idx !== 2'd2 || flush_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midflush_pos got we=%0d idx=%0d busy=%0d exp 1 2 1",
                     btb_we, btb_idx, flush_busy);
        end
        nRST = 1'b0;
        btb_wr_ack = 1'b0;
        cyc();
        nRST = 1'b1;
        exp_cnt = 0;
        n_tests++;
        if ({btb_we, flush_busy, res_ready, install_cnt} !== {3'b001, 16'd0}) begin
            n_fail++;
            $display("FAIL midflush_reset got we=%0d busy=%0d ready=%0d cnt=%0d exp 0 0 1 0",
                     btb_we, flush_busy, res_ready, install_cnt);
        end
        btb_wr_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (flush_done !== 1'b0 || btb_we !== 1'b0) begin
                n_fail++;
                $display("FAIL midflush_quiet got done=%0d we=%0d exp 0 0",
                         flush_done, btb_we);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        btb_wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 30'h40 + 30'(i), 30'h300 + 30'(i));
            exp_q.push_back(mk(1, 30'h40 + 30'(i), 30'h300 + 30'(i)));
            n_tests++;
            if (res_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready got %0d exp 1 at %0d", res_ready, i);
            end
            cyc();
        end
        drive(0, 0, 0, 30'd0, 30'd0);
        cyc();
        n_tests++;
        if (install_cnt !== 16'(exp_cnt) || exp_cnt != 5) begin
            n_fail++;
            $display("FAIL b2b_cnt got %0d exp 5 (model %0d)", install_cnt, exp_cnt);
        end
        n_tests++;
        if (s_install_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_cnt got %0d exp 3", s_install_cnt);
        end
        n_tests++;
        if (exp_q.size() != 0 || btb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain got pending=%0d we=%0d exp 0 0",
                     exp_q.size(), btb_we);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        exp_cnt = 0;
        test_reset();
        test_install();
        test_backpressure();
        test_filter();
        test_flush();
        test_reset_mid_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
